// File: rtl/decode_stage.sv
// decode_stage: IF/ID pipeline register with a combinational instruction decoder and HALT lock-down.
//
// Ports:
//   clk, reset          clock and synchronous active-high reset
//   if_valid_i/ready_o  fetch handshake; if_instr_i/if_pc_i carry the instruction and its PC
//   flush_i             kills the held instruction (taken branch/jump)
//   id_valid_o/ready_i  execute handshake
//   id_pc_o .. id_imm_o decoded fields of the held instruction
//   id_ctrl_o           {halt,jump,branch_ne,branch_eq,mem_wr,mem_rd,alu_src,reg_wr}
//   id_illegal_o        held opcode is the reserved 4'hE
// Optional feature macro DECODE_PERF_EN adds perf_retired_o and perf_stall_o saturating counters.
module decode_stage #(
    parameter int IW  = 18,
    parameter int PCW = 8,
    parameter int RAW = 3
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           if_valid_i,
    output logic           if_ready_o,
    input  logic [IW-1:0]  if_instr_i,
    input  logic [PCW-1:0] if_pc_i,
    input  logic           flush_i,
    output logic           id_valid_o,
    input  logic           id_ready_i,
    output logic [PCW-1:0] id_pc_o,
    output logic [3:0]     id_opcode_o,
    output logic [RAW-1:0] id_rd_o,
    output logic [RAW-1:0] id_rs1_o,
    output logic [RAW-1:0] id_rs2_o,
    output logic [PCW-1:0] id_imm_o,
    output logic [7:0]     id_ctrl_o,
    output logic           id_illegal_o
`ifdef DECODE_PERF_EN
    ,
    output logic [15:0]    perf_retired_o,
    output logic [15:0]    perf_stall_o
`endif
);
    typedef enum logic {RUN, HALTED} state_t;
    state_t         state_q, state_d;
    logic           valid_q, valid_d;
    logic [IW-1:0]  instr_q, instr_d;
    logic [PCW-1:0] pc_q, pc_d;
    logic [3:0]     op;
    logic           if_fire, id_fire, reg_wr, alu_src;
    assign op          = instr_q[17:14];
    // Flush blocks acceptance so the fetch presented in the flush cycle is dropped.
    assign if_ready_o  = (state_q == RUN) && !flush_i && (!valid_q || id_ready_i);
    assign if_fire     = if_valid_i && if_ready_o;
    assign id_fire     = valid_q && id_ready_i;
    assign id_valid_o  = valid_q;
    assign id_pc_o     = pc_q;
    assign id_opcode_o = op;
    assign id_rd_o     = instr_q[13:11];
    assign id_rs1_o    = instr_q[10:8];
    assign id_rs2_o    = instr_q[7:5];
    assign id_imm_o    = PCW'($signed(instr_q[7:0]));
    assign reg_wr      = (op >= 4'h1 && op <= 4'h8) || op == 4'hD;
    assign alu_src     = op inside {4'h7, 4'h8, 4'h9, 4'hD};
    assign id_ctrl_o   = {op == 4'hF, op == 4'hC, op == 4'hB, op == 4'hA,
                          op == 4'h9, op == 4'h8, alu_src, reg_wr};
    assign id_illegal_o = op == 4'hE;
    always_comb begin
        state_d = state_q;
        valid_d = valid_q;
        instr_d = instr_q;
        pc_d    = pc_q;
        if (flush_i) begin
            valid_d = 1'b0;
        end else begin
            if (id_fire) valid_d = 1'b0;
            if (if_fire) begin
                valid_d = 1'b1;
                instr_d = if_instr_i;
                pc_d    = if_pc_i;
            end
            // A retiring HALT locks the stage; anything captured alongside it is discarded.
            if (id_fire && op == 4'hF) begin
                state_d = HALTED;
                valid_d = 1'b0;
            end
        end
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= RUN;
            valid_q <= 1'b0;
            instr_q <= '0;
            pc_q    <= '0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            instr_q <= instr_d;
            pc_q    <= pc_d;
        end
    end
`ifdef DECODE_PERF_EN
    logic [15:0] retired_q, retired_d, stall_q, stall_d;
    assign retired_d = retired_q + 16'(id_fire && retired_q != 16'hFFFF);
    assign stall_d   = stall_q + 16'(valid_q && !id_ready_i && stall_q != 16'hFFFF);
    always_ff @(posedge clk) begin
        if (reset) begin
            retired_q <= '0;
            stall_q   <= '0;
        end else begin
            retired_q <= retired_d;
            stall_q   <= stall_d;
        end
    end
    assign perf_retired_o = retired_q;
    assign perf_stall_o   = stall_q;
`endif
endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: scoreboard bench for decode_stage with directed vectors.
module tb_decode_stage;
    logic        clk = 1'b0, reset = 1'b1;
    logic        if_valid = 1'b0, if_ready, flush = 1'b0, id_valid, id_ready = 1'b0, id_illegal;
    logic [17:0] if_instr = '0;
    logic [7:0]  if_pc = '0, id_pc, id_imm, id_ctrl;
    logic [3:0]  id_opcode;
    logic [2:0]  id_rd, id_rs1, id_rs2;
`ifdef DECODE_PERF_EN
    logic [15:0] perf_retired, perf_stall;
`endif
    int checks = 0, failures = 0;
    logic [37:0] exp_q[$];

    decode_stage dut (
        .clk(clk), .reset(reset),
        .if_valid_i(if_valid), .if_ready_o(if_ready), .if_instr_i(if_instr), .if_pc_i(if_pc),
        .flush_i(flush),
        .id_valid_o(id_valid), .id_ready_i(id_ready), .id_pc_o(id_pc), .id_opcode_o(id_opcode),
        .id_rd_o(id_rd), .id_rs1_o(id_rs1), .id_rs2_o(id_rs2), .id_imm_o(id_imm),
        .id_ctrl_o(id_ctrl), .id_illegal_o(id_illegal)
`ifdef DECODE_PERF_EN
        , .perf_retired_o(perf_retired), .perf_stall_o(perf_stall)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", name, got, exp);
        end
    endtask

    function automatic logic [17:0] mk(input logic [3:0] op, input logic [2:0] rd,
                                       input logic [2:0] rs1, input logic [7:0] lo);
        return {op, rd, rs1, lo};
    endfunction

    // Presents one instruction, waits for acceptance, and records the expected bundle.
    task automatic send(input logic [17:0] ins, input logic [7:0] pc,
                        input logic [7:0] ctrl, input logic ill);
        if_valid = 1'b1;
        if_instr = ins;
        if_pc    = pc;
        for (int n = 0; ; n++) begin
            @(negedge clk);
            if (if_ready) break;
            if (n > 100) begin
                checks++;
                failures++;
                $display("FAIL send_timeout pc=%0h got=no_accept expected=accept", pc);
                if_valid = 1'b0;
                return;
            end
        end
        exp_q.push_back({pc, ins[17:14], ins[13:11], ins[10:8], ins[7:5], ins[7:0], ctrl, ill});
        @(posedge clk);
        #1 if_valid = 1'b0;
    endtask

    task automatic drain();
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    // Monitor: a killed bundle is discarded, a transferred bundle is compared against the scoreboard.
    always @(negedge clk) begin
        if (!reset && id_valid) begin
            if (flush) begin
                if (exp_q.size() > 0) void'(exp_q.pop_front());
            end else if (id_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_bundle got=pc_%0h expected=none", id_pc);
                end else begin
                    chk("bundle", {id_pc, id_opcode, id_rd, id_rs1, id_rs2, id_imm, id_ctrl, id_illegal},
                        exp_q.pop_front());
                end
            end
        end
    end

    logic [17:0] v_ins [13];
    logic [7:0]  v_ctrl[13];
    logic        v_ill [13];

    initial begin
        v_ins  = '{mk(4'h1, 3'd1, 3'd2, 8'h60), mk(4'h2, 3'd4, 3'd5, 8'hE0), mk(4'h7, 3'd3, 3'd1, 8'hFB),
                   mk(4'h8, 3'd2, 3'd6, 8'h04), mk(4'h9, 3'd0, 3'd7, 8'h10), mk(4'hD, 3'd5, 3'd0, 8'h80),
                   mk(4'hB, 3'd0, 3'd1, 8'h40), mk(4'hC, 3'd0, 3'd0, 8'h12), mk(4'hE, 3'd1, 3'd1, 8'h01),
                   mk(4'h0, 3'd0, 3'd0, 8'h00), mk(4'h6, 3'd7, 3'd6, 8'hA0), mk(4'hA, 3'd2, 3'd3, 8'hFE),
                   mk(4'h5, 3'd6, 3'd6, 8'hC0)};
        v_ctrl = '{8'h01, 8'h01, 8'h03, 8'h07, 8'h0A, 8'h03, 8'h20, 8'h40, 8'h00, 8'h00, 8'h01, 8'h10, 8'h01};
        v_ill  = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0};
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("reset_id_valid", id_valid, 0);
        chk("reset_if_ready", if_ready, 1);
        chk("reset_outputs", {id_pc, id_opcode, id_rd, id_rs1, id_rs2, id_imm, id_ctrl, id_illegal}, 0);
        @(posedge clk);
        #1 id_ready = 1'b1;
        for (int i = 0; i < 13; i++) send(v_ins[i], 8'(i), v_ctrl[i], v_ill[i]);
        drain();
        // Backpressure: held bundle and outputs must stay put while execute stalls.
        id_ready = 1'b0;
        send(mk(4'h1, 3'd1, 3'd2, 8'h60), 8'h10, 8'h01, 1'b0);
        if_valid = 1'b1;
        if_instr = mk(4'h2, 3'd3, 3'd4, 8'hA0);
        if_pc    = 8'h11;
        repeat (4) begin
            @(negedge clk);
            chk("stall_if_ready", if_ready, 0);
            chk("stall_id_pc", id_pc, 8'h10);
            chk("stall_id_opcode", id_opcode, 4'h1);
        end
        @(posedge clk);
        #1 id_ready = 1'b1;
        send(mk(4'h2, 3'd3, 3'd4, 8'hA0), 8'h11, 8'h01, 1'b0);
        drain();
        // Flush of a held BEQ while fetch presents a new instruction.
        id_ready = 1'b0;
        send(mk(4'hA, 3'd1, 3'd2, 8'h08), 8'h20, 8'h10, 1'b0);
        flush    = 1'b1;
        if_valid = 1'b1;
        if_instr = mk(4'h2, 3'd1, 3'd1, 8'h20);
        if_pc    = 8'h21;
        @(negedge clk);
        chk("flush_if_ready", if_ready, 0);
        chk("flush_held_opcode", id_opcode, 4'hA);
        @(posedge clk);
        #1 flush = 1'b0;
        if_valid = 1'b0;
        id_ready = 1'b1;
        @(negedge clk);
        chk("flush_id_valid", id_valid, 0);
        drain();
        // HALT retires, then the stage stays locked until reset.
        send(mk(4'hF, 3'd0, 3'd0, 8'h00), 8'h05, 8'h80, 1'b0);
        @(posedge clk);
        #1 if_valid = 1'b1;
        if_instr = mk(4'h1, 3'd1, 3'd1, 8'h20);
        if_pc    = 8'h06;
        repeat (10) begin
            @(negedge clk);
            chk("halt_if_ready", if_ready, 0);
            chk("halt_id_valid", id_valid, 0);
        end
        if_valid = 1'b0;
        reset    = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("post_halt_reset_if_ready", if_ready, 1);
        chk("post_halt_reset_id_valid", id_valid, 0);
        // Six retirements with four stall cycles for the counters.
        @(posedge clk);
        #1 id_ready = 1'b0;
        send(mk(4'h3, 3'd1, 3'd2, 8'h60), 8'h30, 8'h01, 1'b0);
        repeat (4) @(negedge clk);
        @(posedge clk);
        #1 id_ready = 1'b1;
        for (int i = 0; i < 5; i++) send(v_ins[i], 8'(8'h31 + i), v_ctrl[i], v_ill[i]);
        drain();
`ifdef DECODE_PERF_EN
        chk("perf_retired", perf_retired, 6);
        chk("perf_stall", perf_stall, 4);
`endif
        repeat (3) @(negedge clk);
        chk("scoreboard_empty", 64'(exp_q.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
